// File: rtl/sipo_frame_rx_if.sv
// Bundle between a serial bit source and the sipo_frame_rx frame receiver.
// state_dbg mirrors the receiver FSM state for checkers and debug.
interface sipo_frame_rx_if #(
    parameter int WIDTH = 8
);
    // din is consumed only on clock edges where bit_en=1; there is no
    // back-pressure, and valid/frame_err/parity_err are one-cycle pulses.
    logic             din;
    logic             bit_en;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             frame_err;
    logic             parity_err;
    logic             busy;
    logic [1:0]       state_dbg;

    modport master (
        output din,
        output bit_en,
        input  data_out,
        input  valid,
        input  frame_err,
        input  parity_err,
        input  busy,
        input  state_dbg
    );

    modport slave (
        input  din,
        input  bit_en,
        output data_out,
        output valid,
        output frame_err,
        output parity_err,
        output busy,
        output state_dbg
    );
endinterface

// File: rtl/sipo_frame_rx.sv
// Serial-in/parallel-out frame receiver: start(0), WIDTH data bits LSB first,
// optional even parity (define SIPO_FRAME_RX_PARITY_EN), stop(1).
module sipo_frame_rx #(
    parameter int WIDTH = 8
) (
    input  logic           Clk,
    input  logic           rst,
    sipo_frame_rx_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SIPO_FRAME_RX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd3
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
`ifdef SIPO_FRAME_RX_PARITY_EN
    logic             perr_q, perr_d;
    logic             pflag_q, pflag_d;
`endif

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
            perr_q  <= 1'b0;
            pflag_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef SIPO_FRAME_RX_PARITY_EN
            perr_q  <= perr_d;
            pflag_q <= pflag_d;
`endif
        end
    end

    // Pulses default low; everything else holds unless a strobed bit arrives.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef SIPO_FRAME_RX_PARITY_EN
        perr_d  = 1'b0;
        pflag_d = pflag_q;
`endif
        if (bus.bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!bus.din) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    // LSB arrives first, so after WIDTH shifts it sits in bit 0.
                    shreg_d = {bus.din, shreg_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_FRAME_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
`ifdef SIPO_FRAME_RX_PARITY_EN
                PARITY: begin
                    if ((^shreg_q) ^ bus.din) begin
                        pflag_d = 1'b1;
                    end
                    state_d = STOP;
                end
`endif
                STOP: begin
                    if (bus.din) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
`ifdef SIPO_FRAME_RX_PARITY_EN
                        perr_d  = pflag_q;
`endif
                    end else begin
                        ferr_d = 1'b1;
                    end
`ifdef SIPO_FRAME_RX_PARITY_EN
                    pflag_d = 1'b0;
`endif
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
`ifdef SIPO_FRAME_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
    assign bus.busy      = (state_q != IDLE);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx: directed frames from the test plan
// followed by randomized frames checked against a frame-level reference model.
module tb_sipo_frame_rx;
    localparam int WIDTH = 8;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic rst = 1'b0;
    always #5 Clk = ~Clk;

    sipo_frame_rx_if #(.WIDTH(WIDTH)) bus ();

    sipo_frame_rx #(.WIDTH(WIDTH)) dut (
        .Clk (Clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    int               errors = 0;
    int               checks = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_good = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against what the frame-level model expects now.
    task automatic expect_outputs(input logic busy_e, input logic v_e,
                                  input logic fe_e, input logic pe_e);
        if (v_e && exp_q.size() > 0) last_good = exp_q.pop_front();
        check_eq("busy", 32'(bus.busy), 32'(busy_e));
        check_eq("valid", 32'(bus.valid), 32'(v_e));
        check_eq("frame_err", 32'(bus.frame_err), 32'(fe_e));
        check_eq("parity_err", 32'(bus.parity_err), 32'(pe_e));
        check_eq("data_out", 32'(bus.data_out), 32'(last_good));
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change on the falling edge; outputs are checked on the next one.
    task automatic drive_bit(input logic b, input int gap, input logic busy_after,
                             input logic v, input logic fe, input logic pe);
        bus.din    = b;
        bus.bit_en = 1'b1;
        @(negedge Clk);
        expect_outputs(busy_after, v, fe, pe);
        bus.bit_en = 1'b0;
        repeat (gap) begin
            bus.din = 1'($urandom_range(0, 1));
            @(negedge Clk);
            expect_outputs(busy_after, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle_bits(input int n);
        repeat (n) drive_bit(1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop_ok,
                              input logic par_bad, input int gap);
        logic p_err;
        drive_bit(1'b0, gap, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++) drive_bit(d[i], gap, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SIPO_FRAME_RX_PARITY_EN
        drive_bit((^d) ^ par_bad, gap, 1'b1, 1'b0, 1'b0, 1'b0);
        p_err = par_bad;
`else
        p_err = 1'b0;
`endif
        if (stop_ok) exp_q.push_back(d);
        drive_bit(stop_ok, gap, 1'b0, stop_ok, ~stop_ok, stop_ok & p_err);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] rd;
        logic             rstop;
        logic             rpar;
        int               rgap;

        bus.din    = 1'b1;
        bus.bit_en = 1'b0;
        rst        = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            expect_outputs(1'b0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        idle_bits(10);

        send_frame(8'hA5, 1'b1, 1'b0, 0);
        idle_bits(2);
        send_frame(8'hA5, 1'b1, 1'b0, 3);
        idle_bits(1);
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        idle_bits(2);
        send_frame(8'h01, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);

        // Abandon a frame after 4 data bits with an asynchronous reset.
        drive_bit(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'((8'h55 >> i) & 1), 0, 1'b1, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        last_good = '0;
        #1 expect_outputs(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("state_dbg_reset", 32'(bus.state_dbg), 32'd0);
        @(negedge Clk);
        expect_outputs(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        idle_bits(1);
        send_frame(8'h55, 1'b1, 1'b0, 0);

`ifdef SIPO_FRAME_RX_PARITY_EN
        idle_bits(1);
        send_frame(8'hA5, 1'b1, 1'b0, 0);
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        send_frame(8'h3C, 1'b0, 1'b1, 1);
`endif

        for (int n = 0; n < 40; n++) begin
            rd    = WIDTH'($urandom);
            rstop = ($urandom_range(0, 9) != 0);
            rpar  = ($urandom_range(0, 3) == 0);
            rgap  = $urandom_range(0, 3);
            send_frame(rd, rstop, rpar, rgap);
            idle_bits($urandom_range(0, 2));
        end

        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
